// File: rtl/endian_pkg.sv
// Shared types for the endian beat serializer.
package endian_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/endian_byterev.sv
// Combinational byte-lane and mask reversal of a LEN-bit store word.
module endian_byterev #(
    parameter int unsigned LEN = 64
) (
    input  logic [LEN-1:0]   data,
    input  logic [LEN/8-1:0] mask,
    output logic [LEN-1:0]   rev_data,
    output logic [LEN/8-1:0] rev_mask
);

    localparam int unsigned NBYTES = LEN / 8;

    always_comb begin
        rev_data = '0;
        rev_mask = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            rev_data[i*8 +: 8] = data[(NBYTES-1-i)*8 +: 8];
            rev_mask[i]        = mask[NBYTES-1-i];
        end
    end

endmodule

// File: rtl/endian_beat_serializer.sv
// Captures a store word (optionally byte-reversed) and streams it out as
// LEN/BEATW bus beats, lowest beat first, with no bubble between requests.
module endian_beat_serializer
    import endian_pkg::*;
#(
    parameter int unsigned LEN   = 64,
    parameter int unsigned BEATW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic               BigEndian,
    input  logic [LEN-1:0]     WriteData,
    input  logic [LEN/8-1:0]   ByteMask,
    input  logic               Flush,
    output logic               BeatValid,
    input  logic               BeatReady,
    output logic [BEATW-1:0]   BeatData,
    output logic [BEATW/8-1:0] BeatMask,
    output logic               BeatLast,
    output logic               Busy
);

    localparam int unsigned NB = LEN / BEATW;
    localparam int unsigned MW = BEATW / 8;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

    if ((LEN % BEATW) != 0) begin : g_len_check
        $error("endian_beat_serializer: LEN must be a multiple of BEATW");
    end
    if (BEATW < 32) begin : g_beatw_check
        $error("endian_beat_serializer: BEATW must be at least 32");
    end

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [NB-1:0][BEATW-1:0] word_q;
    logic [NB-1:0][MW-1:0]    mask_q;

    logic [LEN-1:0]           rev_data;
    logic [LEN/8-1:0]         rev_mask;
    logic [LEN-1:0]           in_data;
    logic [LEN/8-1:0]         in_mask;
    logic [NB-1:0][BEATW-1:0] in_beats;
    logic [NB-1:0][MW-1:0]    in_masks;

    logic          accept;
    logic          beat_hs;
    logic          last_hs;
    logic [CW-1:0] nxt;

    endian_byterev #(.LEN(LEN)) u_byterev (
        .data     (WriteData),
        .mask     (ByteMask),
        .rev_data (rev_data),
        .rev_mask (rev_mask)
    );

    assign in_data  = BigEndian ? rev_data : WriteData;
    assign in_mask  = BigEndian ? rev_mask : ByteMask;
    assign in_beats = in_data;
    assign in_masks = in_mask;

    assign beat_hs  = BeatValid && BeatReady;
    assign last_hs  = beat_hs && BeatLast;
    assign nxt      = cnt + 1'b1;
    // Accepting during the last-beat handshake lets the next word start with no gap.
    assign ReqReady = reset && !Flush && ((state == IDLE) || last_hs);
    assign accept   = ReqValid && ReqReady;
    assign Busy     = (state == SEND);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            word_q    <= '0;
            mask_q    <= '0;
            BeatValid <= 1'b0;
            BeatData  <= '0;
            BeatMask  <= '0;
            BeatLast  <= 1'b0;
        end else if (Flush) begin
            state     <= IDLE;
            cnt       <= '0;
            BeatValid <= 1'b0;
            BeatLast  <= 1'b0;
        end else if (accept) begin
            state     <= SEND;
            cnt       <= '0;
            word_q    <= in_beats;
            mask_q    <= in_masks;
            BeatValid <= 1'b1;
            BeatData  <= in_beats[0];
            BeatMask  <= in_masks[0];
            BeatLast  <= (NB == 1);
        end else if (last_hs) begin
            state     <= IDLE;
            cnt       <= '0;
            BeatValid <= 1'b0;
            BeatLast  <= 1'b0;
        end else if (beat_hs) begin
            cnt       <= nxt;
            BeatData  <= word_q[nxt];
            BeatMask  <= mask_q[nxt];
            BeatLast  <= (nxt == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_endian_beat_serializer.sv
// Directed self-checking bench for endian_beat_serializer at LEN=64, BEATW=32.
module tb_endian_beat_serializer;

    logic        clk;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        BigEndian;
    logic [63:0] WriteData;
    logic [7:0]  ByteMask;
    logic        Flush;
    logic        BeatValid;
    logic        BeatReady;
    logic [31:0] BeatData;
    logic [3:0]  BeatMask;
    logic        BeatLast;
    logic        Busy;

    int errors = 0;
    int checks = 0;

    endian_beat_serializer #(.LEN(64), .BEATW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .BigEndian (BigEndian),
        .WriteData (WriteData),
        .ByteMask  (ByteMask),
        .Flush     (Flush),
        .BeatValid (BeatValid),
        .BeatReady (BeatReady),
        .BeatData  (BeatData),
        .BeatMask  (BeatMask),
        .BeatLast  (BeatLast),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        be;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [31:0] d0;
        logic [3:0]  m0;
        logic [31:0] d1;
        logic [3:0]  m1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic present(input logic be, input logic [63:0] data, input logic [7:0] mask);
        ReqValid  = 1'b1;
        BigEndian = be;
        WriteData = data;
        ByteMask  = mask;
    endtask

    // Issue a request from idle and check both beats with BeatReady held high.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        BeatReady = 1'b1;
        present(v.be, v.data, v.mask);
        #1 chk({tag, " idle ReqReady"}, 64'(ReqReady), 64'd1);
        @(negedge clk);
        ReqValid = 1'b0;
        chk({tag, " beat0 valid"}, 64'(BeatValid), 64'd1);
        chk({tag, " beat0 data"}, 64'(BeatData), 64'(v.d0));
        chk({tag, " beat0 mask"}, 64'(BeatMask), 64'(v.m0));
        chk({tag, " beat0 last"}, 64'(BeatLast), 64'd0);
        @(negedge clk);
        chk({tag, " beat1 valid"}, 64'(BeatValid), 64'd1);
        chk({tag, " beat1 data"}, 64'(BeatData), 64'(v.d1));
        chk({tag, " beat1 mask"}, 64'(BeatMask), 64'(v.m1));
        chk({tag, " beat1 last"}, 64'(BeatLast), 64'd1);
        @(negedge clk);
        chk({tag, " done valid"}, 64'(BeatValid), 64'd0);
        chk({tag, " done busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'h1122334455667788, 8'hFF, 32'h55667788, 4'hF, 32'h11223344, 4'hF};
        vecs[1] = '{1'b1, 64'h1122334455667788, 8'h0F, 32'h44332211, 4'h0, 32'h88776655, 4'hF};
        vecs[2] = '{1'b0, 64'hDEADBEEFCAFEF00D, 8'h0F, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 4'h0};
        vecs[3] = '{1'b1, 64'h0102030405060708, 8'h81, 32'h04030201, 4'h1, 32'h08070605, 4'h8};
        vecs[4] = '{1'b0, 64'h0F1E2D3C4B5A6978, 8'h00, 32'h4B5A6978, 4'h0, 32'h0F1E2D3C, 4'h0};
        vecs[5] = '{1'b1, 64'hA1B2C3D4E5F60718, 8'h12, 32'hD4C3B2A1, 4'h8, 32'h1807F6E5, 4'h4};

        reset     = 1'b0;
        ReqValid  = 1'b1;
        BigEndian = 1'b0;
        WriteData = 64'h1122334455667788;
        ByteMask  = 8'hFF;
        Flush     = 1'b0;
        BeatReady = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ReqReady", 64'(ReqReady), 64'd0);
        chk("reset BeatValid", 64'(BeatValid), 64'd0);
        chk("reset BeatData", 64'(BeatData), 64'd0);
        chk("reset BeatMask", 64'(BeatMask), 64'd0);
        chk("reset BeatLast", 64'(BeatLast), 64'd0);
        chk("reset Busy", 64'(Busy), 64'd0);
        ReqValid = 1'b0;
        reset    = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure on beat0, then a back-to-back request during the last beat.
        @(negedge clk);
        present(1'b0, 64'h1122334455667788, 8'hFF);
        @(negedge clk);
        ReqValid  = 1'b0;
        BeatReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp valid", 64'(BeatValid), 64'd1);
            chk("bp data held", 64'(BeatData), 64'h55667788);
            chk("bp ReqReady", 64'(ReqReady), 64'd0);
            @(negedge clk);
        end
        chk("bp still beat0", 64'(BeatData), 64'h55667788);
        BeatReady = 1'b1;
        @(negedge clk);
        chk("bp beat1 data", 64'(BeatData), 64'h11223344);
        chk("bp beat1 last", 64'(BeatLast), 64'd1);
        present(1'b1, 64'h1122334455667788, 8'h0F);
        #1 chk("b2b ReqReady on last", 64'(ReqReady), 64'd1);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("b2b beat0 valid", 64'(BeatValid), 64'd1);
        chk("b2b busy", 64'(Busy), 64'd1);
        chk("b2b beat0 data", 64'(BeatData), 64'h44332211);
        chk("b2b beat0 mask", 64'(BeatMask), 64'h0);
        @(negedge clk);
        chk("b2b beat1 data", 64'(BeatData), 64'h88776655);
        chk("b2b beat1 mask", 64'(BeatMask), 64'hF);
        chk("b2b beat1 last", 64'(BeatLast), 64'd1);
        @(negedge clk);
        chk("b2b idle valid", 64'(BeatValid), 64'd0);

        // Flush after beat0 handshake; a request offered in the flush cycle is refused.
        present(1'b0, 64'h1122334455667788, 8'hFF);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("fl beat0 data", 64'(BeatData), 64'h55667788);
        @(negedge clk);
        chk("fl beat1 data", 64'(BeatData), 64'h11223344);
        Flush = 1'b1;
        present(1'b1, 64'h0102030405060708, 8'h81);
        #1 chk("fl ReqReady", 64'(ReqReady), 64'd0);
        @(negedge clk);
        Flush = 1'b0;
        chk("fl valid", 64'(BeatValid), 64'd0);
        chk("fl busy", 64'(Busy), 64'd0);
        #1 chk("fl ReqReady after", 64'(ReqReady), 64'd1);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("fl new beat0 data", 64'(BeatData), 64'h04030201);
        chk("fl new beat0 mask", 64'(BeatMask), 64'h1);
        @(negedge clk);
        chk("fl new beat1 data", 64'(BeatData), 64'h08070605);
        @(negedge clk);

        // Reset in the middle of a transfer.
        present(1'b0, 64'hDEADBEEFCAFEF00D, 8'hFF);
        @(negedge clk);
        ReqValid = 1'b0;
        chk("rst beat0 data", 64'(BeatData), 64'hCAFEF00D);
        reset     = 1'b0;
        BeatReady = 1'b0;
        @(negedge clk);
        chk("rst mid valid", 64'(BeatValid), 64'd0);
        chk("rst mid data", 64'(BeatData), 64'd0);
        chk("rst mid mask", 64'(BeatMask), 64'd0);
        chk("rst mid last", 64'(BeatLast), 64'd0);
        chk("rst mid busy", 64'(Busy), 64'd0);
        chk("rst mid ReqReady", 64'(ReqReady), 64'd0);
        reset = 1'b1;
        run_vec(vecs[0], "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
